ntt_coef_gather: RTL

//  Write-back reorder stage for the NTT datapath. Collects 96-bit butterfly result words (4 x 24-bit coeffs).

---
 rtl/ntt_pkg.sv | 27 ++
 rtl/ntt_coef_gather_if.sv | 29 ++
 rtl/ntt_gather_bank.sv | 59 +++++
 rtl/ntt_coef_gather.sv | 110 +++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared constants for the NTT write-back path: word geometry and operating modes.
package ntt_pkg;

   localparam int unsigned COEF_W         = 24;
   localparam int unsigned LANES          = 4;
   localparam int unsigned ADDR_W         = 6;
   localparam int unsigned WORDS_PER_POLY = 64;
   localparam int unsigned WORD_W         = COEF_W * LANES;

   localparam logic [2:0] FWD_NTT = 3'd0;
   localparam logic [2:0] INV_NTT = 3'd1;
   localparam logic [2:0] MULT    = 3'd2;
   localparam logic [2:0] ADD     = 3'd3;
   localparam logic [2:0] SUB     = 3'd4;

   typedef enum logic [0:0] {
      StIdle,
      StBusy
   } gather_state_e;

   // Extract coefficient lane k of a word.
   function automatic logic [COEF_W-1:0] lane_of(input logic [WORD_W-1:0] w,
                                                 input logic [1:0]        k);
      return w[k*COEF_W +: COEF_W];
   endfunction

endpackage

// File: rtl/ntt_coef_gather_if.sv
// Control, input stream and output stream of the coefficient gather stage.
interface ntt_coef_gather_if;
   import ntt_pkg::*;

   logic                start;
   logic [2:0]          mode;
   logic                in_valid;
   logic                in_ready;
   logic [WORD_W-1:0]   in_data;
   logic                out_valid;
   logic                out_ready;
   logic [WORD_W-1:0]   out_data;
   logic [ADDR_W-1:0]   out_addr;
   logic                busy;
   logic                done;

   // Producer/consumer side that drives the gather stage.
   modport master (
      output start, mode, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_addr, busy, done
   );

   // The gather stage itself.
   modport slave (
      input  start, mode, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_addr, busy, done
   );

endinterface

// File: rtl/ntt_gather_bank.sv
// One 4x4 coefficient bank: row-wise fill, column-wise (optionally transposed) read.
module ntt_gather_bank
   import ntt_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              wr_en,
   input  logic [1:0]        wr_row,
   input  logic [WORD_W-1:0] wr_data,
   input  logic              free,
   input  logic [1:0]        rd_col,
   input  logic              transpose,
   output logic              full,
   output logic [WORD_W-1:0] rd_data
);

   logic [WORD_W-1:0] rows_q [LANES];
   logic              full_q;

   // Row storage; cleared on reset and on a new polynomial.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < LANES; r++) rows_q[r] <= '0;
      end else if (clear) begin
         for (int r = 0; r < LANES; r++) rows_q[r] <= '0;
      end else if (wr_en) begin
         rows_q[wr_row] <= wr_data;
      end
   end

   // Full flag: set by the last row write, dropped when the drain side frees the bank.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q <= 1'b0;
      end else if (clear) begin
         full_q <= 1'b0;
      end else if (wr_en && (wr_row == 2'd3)) begin
         full_q <= 1'b1;
      end else if (free) begin
         full_q <= 1'b0;
      end
   end

   // Column read: transposed gathers lane rd_col of every row, otherwise row rd_col as stored.
   always_comb begin
      rd_data = '0;
      if (transpose) begin
         for (int k = 0; k < LANES; k++) begin
            rd_data[k*COEF_W +: COEF_W] = lane_of(rows_q[k], rd_col);
         end
      end else begin
         rd_data = rows_q[rd_col];
      end
   end

   assign full = full_q;

endmodule

// File: rtl/ntt_coef_gather.sv
// Write-back reorder stage: ping-pong 4x4 banks, transpose in forward NTT, pass-through otherwise.
module ntt_coef_gather
   import ntt_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   ntt_coef_gather_if.slave   bus
);

   gather_state_e     state_q, state_d;
   logic [2:0]        mode_q;
   logic [ADDR_W:0]   in_cnt_q;
   logic [ADDR_W-1:0] out_cnt_q;
   logic              fill_ptr_q;
   logic              drain_ptr_q;

   logic              bank_full [2];
   logic [WORD_W-1:0] bank_rd   [2];

   logic              busy;
   logic              in_ready;
   logic              in_acc;
   logic              out_valid;
   logic              out_acc;
   logic              last_out;
   logic [1:0]        col;

   assign busy      = (state_q == StBusy);
   // in_cnt_q MSB set means all 64 words of the polynomial have been taken.
   assign in_ready  = busy && !bank_full[fill_ptr_q] && !in_cnt_q[ADDR_W];
   assign out_valid = bank_full[drain_ptr_q];
   assign col       = out_cnt_q[1:0];
   // start overrides any handshake in the same cycle.
   assign in_acc    = bus.in_valid && in_ready && !bus.start;
   assign out_acc   = out_valid && bus.out_ready && !bus.start;
   assign last_out  = out_acc && (out_cnt_q == '1);

   // Two ping-pong banks; fill and drain pointers select which one each side uses.
   for (genvar b = 0; b < 2; b++) begin : g_bank
      ntt_gather_bank u_bank (
         .clk       (clk),
         .rst_n     (rst_n),
         .clear     (bus.start),
         .wr_en     (in_acc && (fill_ptr_q == 1'(b))),
         .wr_row    (in_cnt_q[1:0]),
         .wr_data   (bus.in_data),
         .free      (out_acc && (col == 2'd3) && (drain_ptr_q == 1'(b))),
         .rd_col    (col),
         .transpose (mode_q == FWD_NTT),
         .full      (bank_full[b]),
         .rd_data   (bank_rd[b])
      );
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: start always (re)enters busy; accepting the last output word returns to idle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (bus.start) state_d = StBusy;
         StBusy:  if (!bus.start && last_out) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Mode, counters and bank pointers; start clears everything and latches the new mode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q      <= FWD_NTT;
         in_cnt_q    <= '0;
         out_cnt_q   <= '0;
         fill_ptr_q  <= 1'b0;
         drain_ptr_q <= 1'b0;
      end else if (bus.start) begin
         mode_q      <= bus.mode;
         in_cnt_q    <= '0;
         out_cnt_q   <= '0;
         fill_ptr_q  <= 1'b0;
         drain_ptr_q <= 1'b0;
      end else begin
         if (in_acc) begin
            in_cnt_q <= in_cnt_q + 1'b1;
            if (in_cnt_q[1:0] == 2'd3) fill_ptr_q <= !fill_ptr_q;
         end
         if (out_acc) begin
            out_cnt_q <= out_cnt_q + 1'b1;
            if (col == 2'd3) drain_ptr_q <= !drain_ptr_q;
         end
      end
   end

   // Output drive; data is forced to zero whenever no word is offered.
   always_comb begin
      bus.in_ready  = in_ready;
      bus.out_valid = out_valid;
      bus.out_data  = out_valid ? bank_rd[drain_ptr_q] : '0;
      bus.out_addr  = out_cnt_q;
      bus.busy      = busy;
      bus.done      = last_out;
   end

endmodule
